// File: rtl/serial_record_loader.sv
// -----------------------------------------------------------------------------
// serial_record_loader
//
// Serial-to-parallel front end for the regression core. A LANES-wide serial
// stream is deserialised into WORD_W-bit words. Groups of (feat_l+1) words
// form one record, which is written to the dataset RAM in a single wide write.
//
// Handshake: s_en is a valid-only qualifier. In LOAD every cycle with s_en=1
// consumes one LANES-bit group; there is no ready/back-pressure. wr_en is a
// one-cycle valid with no ready, so the RAM must accept every write. start is
// a one-cycle request that is accepted only in IDLE or DONE.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   start        load request (honoured in IDLE/DONE)
//   feat         feature count, latched on an accepted start (clamped)
//   data_points  index of the last record, latched on an accepted start
//   s_en, S      serial lane group valid / lane data (lane k = group bit k)
//   wr_en        one-cycle record write strobe
//   wr_addr      record index of the write
//   wr_data      record; slot n at [n*WORD_W +: WORD_W]
//   busy         high in LOAD
//   done_        high in DONE (sticky until the next accepted start)
//   cfg_err      latched feat exceeded MAX_FEATURES
//   state_dbg    current FSM state (0 IDLE, 1 LOAD, 2 DONE)
// -----------------------------------------------------------------------------
module serial_record_loader #(
    parameter int WORD_W       = 16,
    parameter int MAX_FEATURES = 15,
    parameter int ADDR_WIDTH   = 12,
    parameter int LANES        = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                start,
    input  logic [3:0]                          feat,
    input  logic [ADDR_WIDTH-1:0]               data_points,
    input  logic                                s_en,
    input  logic [LANES-1:0]                    S,
    output logic                                wr_en,
    output logic [ADDR_WIDTH-1:0]               wr_addr,
    output logic [WORD_W*(MAX_FEATURES+1)-1:0]  wr_data,
    output logic                                busy,
    output logic                                done_,
    output logic                                cfg_err,
    output logic [1:0]                          state_dbg
);

    localparam int SLOTS = MAX_FEATURES + 1;
    localparam int REC_W = WORD_W * SLOTS;
    localparam int BW    = $clog2(WORD_W + 1);
    localparam int IW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [BW-1:0] LAST_CNT = BW'(WORD_W - LANES);
    localparam logic [BW-1:0] STEP     = BW'(LANES);
    localparam logic [3:0]    MAX_F    = 4'(MAX_FEATURES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]            feat_l_q;
    logic [ADDR_WIDTH-1:0] dp_l_q;
    logic                  cfg_err_q;
    logic [BW-1:0]         bitcnt_q;
    logic [3:0]            slot_q;
    logic [ADDR_WIDTH-1:0] rec_addr_q;
    logic [WORD_W-1:0]     word_q;
    logic [REC_W-1:0]      rec_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [REC_W-1:0]      wr_data_q;

    logic                  start_ok;
    logic                  take;
    logic                  word_last;
    logic                  rec_last;
    logic                  load_end;
    logic                  feat_over;
    logic [3:0]            feat_clamped;
    logic [WORD_W-1:0]     word_next;
    logic [REC_W-1:0]      rec_next;
    logic [BW-1:0]         pos;

    assign start_ok     = start && (state_q != LOAD);
    assign take         = (state_q == LOAD) && s_en;
    assign word_last    = take && (bitcnt_q == LAST_CNT);
    assign rec_last     = word_last && (slot_q == 4'd0);
    assign load_end     = rec_last && (rec_addr_q == dp_l_q);
    assign feat_over    = (int'(feat) > MAX_FEATURES);
    assign feat_clamped = feat_over ? MAX_F : feat;

    // Current word with this cycle's lane group merged in. In MSB-first mode
    // the word is filled from the top bit downwards.
    always_comb begin
        word_next = word_q;
        pos       = '0;
        for (int k = 0; k < LANES; k++) begin
            pos = bitcnt_q + BW'(k);
            if (MSB_FIRST != 0) begin
                pos = BW'(WORD_W - 1) - pos;
            end
            word_next[pos[IW-1:0]] = S[k];
        end
    end

    // Record with the just-completed word placed in the current slot. Slots
    // count down from feat_l to 0, so the first word lands in the top slot.
    always_comb begin
        rec_next = rec_q;
        for (int n = 0; n < SLOTS; n++) begin
            if (slot_q == 4'(n)) begin
                rec_next[n*WORD_W +: WORD_W] = word_next;
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (load_end) state_d = DONE;
            DONE:    if (start_ok) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath. The write registers are loaded on the edge that samples the
    // last bit of a record, giving a one-cycle latency; the accumulator is
    // cleared on the same edge so the next record can start immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            feat_l_q   <= '0;
            dp_l_q     <= '0;
            cfg_err_q  <= 1'b0;
            bitcnt_q   <= '0;
            slot_q     <= '0;
            rec_addr_q <= '0;
            word_q     <= '0;
            rec_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_ok) begin
                feat_l_q   <= feat_clamped;
                cfg_err_q  <= feat_over;
                dp_l_q     <= data_points;
                bitcnt_q   <= '0;
                slot_q     <= feat_clamped;
                rec_addr_q <= '0;
                word_q     <= '0;
                rec_q      <= '0;
            end else if (take) begin
                if (word_last) begin
                    word_q   <= '0;
                    bitcnt_q <= '0;
                    if (rec_last) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= rec_addr_q;
                        wr_data_q  <= rec_next;
                        rec_q      <= '0;
                        slot_q     <= feat_l_q;
                        rec_addr_q <= rec_addr_q + ADDR_WIDTH'(1);
                    end else begin
                        rec_q  <= rec_next;
                        slot_q <= slot_q - 4'd1;
                    end
                end else begin
                    word_q   <= word_next;
                    bitcnt_q <= bitcnt_q + STEP;
                end
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q == LOAD);
    assign done_     = (state_q == DONE);
    assign cfg_err   = cfg_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_record_loader.sv
// -----------------------------------------------------------------------------
// Bench for serial_record_loader. Three instances cover the build variants:
//   u_a : defaults (LANES=1, LSB first, MAX_FEATURES=15)
//   u_b : LANES=4, MSB first
//   u_c : MAX_FEATURES=7
// Drivers push the expected record write (instance, done flag, address,
// cycle, data) into exp_q; a negedge monitor pops an entry for every wr_en.
// -----------------------------------------------------------------------------
module tb_serial_record_loader;

    localparam int W = 2 + 1 + 12 + 32 + 256;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // shared drive variables, steered to one instance by sel
    int          sel       = 0;
    logic        drv_start = 1'b0;
    logic        drv_en    = 1'b0;
    logic [3:0]  drv_s     = '0;
    logic [3:0]  drv_feat  = '0;
    logic [11:0] drv_dp    = '0;

    logic start_a, start_b, start_c, s_en_a, s_en_b, s_en_c;
    assign start_a = drv_start && (sel == 0);
    assign start_b = drv_start && (sel == 1);
    assign start_c = drv_start && (sel == 2);
    assign s_en_a  = drv_en && (sel == 0);
    assign s_en_b  = drv_en && (sel == 1);
    assign s_en_c  = drv_en && (sel == 2);

    logic         wr_en_a, wr_en_b, wr_en_c;
    logic [11:0]  wr_addr_a, wr_addr_b, wr_addr_c;
    logic [255:0] wr_data_a, wr_data_b;
    logic [127:0] wr_data_c;
    logic         busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic         cfg_err_a, cfg_err_b, cfg_err_c;
    logic [1:0]   state_a, state_b, state_c;

    serial_record_loader u_a (
        .CLK(clk), .RST(rst), .start(start_a), .feat(drv_feat), .data_points(drv_dp),
        .s_en(s_en_a), .S(drv_s[0]), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .done_(done_a), .cfg_err(cfg_err_a),
        .state_dbg(state_a)
    );

    serial_record_loader #(.LANES(4), .MSB_FIRST(1)) u_b (
        .CLK(clk), .RST(rst), .start(start_b), .feat(drv_feat), .data_points(drv_dp),
        .s_en(s_en_b), .S(drv_s), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .done_(done_b), .cfg_err(cfg_err_b),
        .state_dbg(state_b)
    );

    serial_record_loader #(.MAX_FEATURES(7)) u_c (
        .CLK(clk), .RST(rst), .start(start_c), .feat(drv_feat), .data_points(drv_dp),
        .s_en(s_en_c), .S(drv_s[0]), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_data(wr_data_c), .busy(busy_c), .done_(done_c), .cfg_err(cfg_err_c),
        .state_dbg(state_c)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon_one(input logic [W-1:0] act);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL unexpected_write: got %h expected no write", act);
        end else begin
            e = exp_q.pop_front();
            check("write", act, e);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en_a) mon_one({2'd0, done_a, wr_addr_a, 32'(cyc), wr_data_a});
        if (wr_en_b) mon_one({2'd1, done_b, wr_addr_b, 32'(cyc), wr_data_b});
        if (wr_en_c) mon_one({2'd2, done_c, wr_addr_c, 32'(cyc), 256'(wr_data_c)});
    end

    // drivers
    logic [15:0] wbuf[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d, input logic [3:0] f, input logic [11:0] dp);
        sel       = d;
        drv_feat  = f;
        drv_dp    = dp;
        drv_start = 1'b1;
        step();
        drv_start = 1'b0;
    endtask

    // One word in lane groups; optional random idle cycles before each group.
    task automatic send_word(input logic [15:0] w, input int lanes, input int msb,
                             input int stall, output int last_cyc);
        for (int g = 0; g < 16 / lanes; g++) begin
            for (int guard = 0; guard < 20 && $urandom_range(0, 99) < stall; guard++) begin
                drv_en = 1'b0;
                step();
            end
            drv_en = 1'b1;
            drv_s  = '0;
            for (int k = 0; k < lanes; k++) begin
                drv_s[k] = (msb != 0) ? w[15 - g*lanes - k] : w[g*lanes + k];
            end
            step();
            drv_en = 1'b0;
            drv_s  = '0;
        end
        last_cyc = cyc;
    endtask

    // Sends wbuf[0..featl] in arrival order; arrival i lands in slot featl-i.
    task automatic send_record(input int d, input int featl, input int stall,
                               input logic [11:0] addr, input logic done_exp);
        logic [255:0] data;
        int           c;
        int           lanes;
        data  = '0;
        c     = 0;
        lanes = (d == 1) ? 4 : 1;
        for (int i = 0; i <= featl; i++) begin
            data[(featl - i)*16 +: 16] = wbuf[i];
            send_word(wbuf[i], lanes, (d == 1) ? 1 : 0, stall, c);
        end
        exp_q.push_back({2'(d), done_exp, addr, 32'(c), data});
    endtask

    int c_dummy;

    initial begin
        // reset
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_a", W'({wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a, cfg_err_a, state_a}), '0);
        check("reset_b", W'({wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b, cfg_err_b, state_b}), '0);
        check("reset_c", W'({wr_en_c, wr_addr_c, wr_data_c, busy_c, done_c, cfg_err_c, state_c}), '0);

        // two records of three words, LSB first
        pulse_start(0, 4'd2, 12'd1);
        check("a_start_status", W'({busy_a, done_a, cfg_err_a}), W'(3'b100));
        wbuf[0] = 16'h0003; wbuf[1] = 16'h0002; wbuf[2] = 16'h0001;
        send_record(0, 2, 0, 12'd0, 1'b0);
        // start while loading must be ignored
        pulse_start(0, 4'd5, 12'd3);
        check("a_start_in_load", W'({busy_a, done_a}), W'(2'b10));
        wbuf[0] = 16'h0013; wbuf[1] = 16'h0012; wbuf[2] = 16'h0011;
        send_record(0, 2, 0, 12'd1, 1'b1);
        check("a_done_status", W'({busy_a, done_a, state_a}), W'(4'b0110));
        // bits in DONE are ignored; outputs hold the last write
        send_word(16'hFFFF, 1, 0, 0, c_dummy);
        step();
        check("a_hold", W'({wr_en_a, done_a, wr_addr_a, wr_data_a}),
              W'({1'b0, 1'b1, 12'd1, 256'h0013_0012_0011}));
        // restart from DONE
        pulse_start(0, 4'd1, 12'd0);
        check("a_restart_status", W'({busy_a, done_a}), W'(2'b10));
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'h5555;
        send_record(0, 1, 0, 12'd0, 1'b1);
        check("a_restart_done", W'(done_a), W'(1'b1));

        // LANES=4, MSB first, single-word records
        pulse_start(1, 4'd0, 12'd2);
        wbuf[0] = 16'hABCD; send_record(1, 0, 0, 12'd0, 1'b0);
        wbuf[0] = 16'h1234; send_record(1, 0, 0, 12'd1, 1'b0);
        wbuf[0] = 16'hFFFF; send_record(1, 0, 0, 12'd2, 1'b1);
        check("b_done", W'({busy_b, done_b}), W'(2'b01));

        // same stream with s_en gaps
        pulse_start(1, 4'd0, 12'd2);
        wbuf[0] = 16'hABCD; send_record(1, 0, 30, 12'd0, 1'b0);
        wbuf[0] = 16'h1234; send_record(1, 0, 30, 12'd1, 1'b0);
        wbuf[0] = 16'hFFFF; send_record(1, 0, 30, 12'd2, 1'b1);
        check("b_stall_done", W'({busy_b, done_b}), W'(2'b01));

        // reset after 20 bits of record 0: no write, all outputs cleared
        pulse_start(0, 4'd2, 12'd0);
        send_word(16'h0003, 1, 0, 0, c_dummy);
        for (int i = 0; i < 4; i++) begin
            drv_en = 1'b1;
            drv_s  = 4'd1;
            step();
        end
        drv_en = 1'b0;
        drv_s  = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("a_mid_reset", W'({wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a, cfg_err_a, state_a}), '0);
        step();
        check("a_post_reset_idle", W'({wr_en_a, state_a}), '0);
        pulse_start(0, 4'd2, 12'd0);
        wbuf[0] = 16'h0007; wbuf[1] = 16'h0008; wbuf[2] = 16'h0009;
        send_record(0, 2, 0, 12'd0, 1'b1);

        // full-width record on MAX_FEATURES=15
        pulse_start(0, 4'd15, 12'd0);
        check("a_cfg_err_15", W'(cfg_err_a), W'(1'b0));
        for (int i = 0; i < 16; i++) wbuf[i] = 16'h0100 + 16'(i);
        send_record(0, 15, 0, 12'd0, 1'b1);

        // feat=15 clamped to 7 on MAX_FEATURES=7
        pulse_start(2, 4'd15, 12'd0);
        check("c_cfg_err_set", W'({busy_c, cfg_err_c}), W'(2'b11));
        for (int i = 0; i < 8; i++) wbuf[i] = 16'h0200 + 16'(i);
        send_record(2, 7, 0, 12'd0, 1'b1);
        check("c_done_cfg_err", W'({done_c, cfg_err_c}), W'(2'b11));
        pulse_start(2, 4'd3, 12'd0);
        check("c_cfg_err_clear", W'({busy_c, done_c, cfg_err_c}), W'(3'b100));

        repeat (5) step();
        check("queue_empty", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_record_loader.md
Name: serial_record_loader

Overview:
- Parametrised serial-to-parallel front end for the regression core.
- Deserialises a multi-lane serial bit stream into fixed-width words and groups the words into records of (feat+1) words: feature slots plus the y slot.
- Writes each completed record to the dataset RAM in one wide write.
- Adds over the single-lane, free-running loader: an explicit start/enable handshake, lane width, selectable bit order, a done flag and a config-error flag.

Parameters:
- WORD_W, 16: bits per word; must be a multiple of LANES.
- MAX_FEATURES, 15: maximum feature count; a record holds MAX_FEATURES+1 slots.
- ADDR_WIDTH, 12: width of the record address and record count.
- LANES, 1: serial bits accepted per enabled cycle.
- MSB_FIRST, 0: 0 means each word arrives LSB first; 1 means MSB first.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- feat  in  4  feature count; latched on an accepted start.
- data_points  in  ADDR_WIDTH  index of the last record; latched on start; records loaded = data_points+1.
- s_en  in  1  serial lanes valid this cycle.
- S  in  LANES  serial data; lane k carries bit k of the current LANES-bit group.
- wr_en  out  1  one-cycle record write strobe.
- wr_addr  out  ADDR_WIDTH  record index, 0..data_points.
- wr_data  out  WORD_W*(MAX_FEATURES+1)  record data; slot n occupies bits [n*WORD_W +: WORD_W].
- busy  out  1  high in LOAD.
- done_  out  1  sticky completion flag.
- cfg_err  out  1  high when the latched feat exceeds MAX_FEATURES.

Behaviour:
- Reset (CLK edge with RST=1): state IDLE; all counters and the shift register cleared; wr_en, wr_addr, wr_data, busy, done_ and cfg_err all 0. Reset has priority over every other input, including mid-record; partial data is discarded and no write occurs.
- States:
  - IDLE: on start, go to LOAD and latch config.
  - LOAD: on the final bit of the final record, go to DONE.
  - DONE: on start, go to LOAD; done_ clears the cycle start is accepted. Otherwise stay in DONE.
- Config latch:
  - feat_l = feat; if feat > MAX_FEATURES, then feat_l = MAX_FEATURES and cfg_err=1 until the next accepted start.
  - dp_l = data_points.
- start while in LOAD: ignored.
- Bit capture, LOAD with s_en=1:
  - The bit counter advances by LANES.
  - LSB-first mode: lane k fills word bit (bitcnt+k).
  - MSB-first mode: lane k fills word bit (WORD_W-1-bitcnt-k).
  - s_en=0 stalls all counters with no loss of data.
- Word order within a record:
  - The first word received goes to slot feat_l, the next to feat_l-1, and so on down to slot 0.
  - A record completes after feat_l+1 words.
  - Slots above feat_l read as 0 in wr_data.
- Write:
  - wr_en=1 for exactly one cycle, on the cycle after the edge that samples the record's last bit. Latency is 1 cycle.
  - wr_addr and wr_data are valid with wr_en and hold until the next write.
  - Record n writes to address n.
- Back-to-back records: the next record's first bits may arrive on the same cycle wr_en is high; no bit is dropped.
- Completion: after the write of record dp_l, the block goes to DONE and done_=1 in the same cycle as that final wr_en. Further s_en bits are ignored.
- Edge cases:
  - dp_l=0 gives exactly one record.
  - dp_l=2^ADDR_WIDTH-1 writes every address with no wrap.
  - feat_l=0 gives single-word records.
- wr_en is never asserted outside LOAD, except for the final write on the DONE entry cycle.

Test Plan:
- Reset, then start with feat=2, data_points=1, LANES=1, LSB-first. Send words 0x0003,0x0002,0x0001 then 0x0013,0x0012,0x0011 -> addr0 slots{2,1,0}={3,2,1}, addr1={13,12,11}; slots 3..15 zero; each wr_en 1 cycle after its record's last bit; done_ with the second write.
- LANES=4, MSB_FIRST=1, feat=0, data_points=2. Send words 0xABCD, 0x1234, 0xFFFF at 4 cycles/word -> writes to addr 0,1,2 with slot0 equal to those words; the writes come 4 cycles apart.
- Same stream with s_en low for random cycles (30% duty) -> identical writes and data; only the timing stretches.
- RST pulsed after 20 bits of record 0 -> all outputs 0 and no write. A new start and a clean stream then give a correct addr0.
- feat=15 with MAX_FEATURES=15, then start with feat=15 on a build with MAX_FEATURES=7 -> the first case has cfg_err=0 and all 16 slots filled. The second has cfg_err=1 and 8-word records.
- A start during LOAD is ignored. A start in DONE clears done_ and reloads from addr 0.
